pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
// Clocked initiator for the ProgramCounter's four-phase req/ack step interface. It drives
//   req_prev and the 2-bit PC op, and waits for ack_prev.
// Each instruction runs in order: fetch the word at the PC address, decode the MC14500B
//   opcode, hand ALU opcodes to the execute unit, then step the PC with INC/JMP/RTN/CALL.
// Sits between program ROM, execute unit and ProgramCounter.
// PARAMETERS
// ADDR_WIDTH        8   program address width; ROM word = {opcode[3:0], operand[ADDR_WIDTH-1:0]}
// STACK_ADDR_WIDTH  2   PC return-stack pointer width; tracked depth limit = 2**STACK_ADDR_WIDTH-1
// PORTS
// clk           in   1   rising-edge clock
// reset         in   1   reset, asynchronous, active-high
// run           in   1   level; 1 = keep executing, 0 = stop at next instruction boundary
// busy          out  1   1 whenever FSM not IDLE
// pc_req        out  1   to PC req_prev; registered
// pc_ack        in   1   from PC ack_prev; asynchronous, 2-flop synchronised internally
// pc_op         out  2   to PC instruction: 00 INC, 01 JMP, 10 RTN, 11 CALL
// pc_target     out  AW  to PC address_in (JMP/CALL target)
// pc_addr       in   AW  from PC address_out (current instruction address)
// rom_addr      out  AW  program ROM address
// rom_data      in   4+AW  ROM word, valid 1 clk after rom_addr (synchronous ROM)
// exec_valid    out  1   instruction offered to execute unit
// exec_ready    in   1   execute unit accepts; transfer when valid&&ready
// exec_opcode   out  4   opcode 0x0-0xB
// exec_operand  out  AW  I/O/memory operand
// rr            in   1   execute-unit result register; sampled for SKZ
// stack_err     out  1   sticky: CALL at full depth or RTN at depth 0
// BEHAVIOUR
// Reset values: state IDLE; all outputs 0; depth 0; stack_err 0.
// States: IDLE -> FETCH -> CAPTURE -> EXEC -> STEP_REQ -> STEP_REL -> (STEP_REQ | FETCH | IDLE).
// IDLE: leave when run=1.
// FETCH: rom_addr<=pc_addr, 1 clk.
// CAPTURE: latch rom_data into opcode/operand regs, 1 clk.
// EXEC: opcodes 0x0-0xB only; exec_valid=1 with opcode/operand held until exec_ready.
//   Opcodes 0xC-0xF skip EXEC.
// Step plan, decided on leaving CAPTURE/EXEC:
//   0x0-0xB -> INC.
//   0xC JMP -> JMP operand.
//   0xD RTN -> RTN then INC (PC resumes past the CALL).
//   0xE SKZ -> INC; a second INC if rr==0, with rr sampled on leaving CAPTURE.
//   0xF NOPF -> CALL operand.
// STEP_REQ: pc_op/pc_target set, pc_req=1; wait for synced ack=1.
// STEP_REL: pc_req=0; wait for synced ack=0.
//   Then: a pending second step -> STEP_REQ; else run ? FETCH : IDLE.
// Four-phase rule: pc_op/pc_target stable from the cycle before pc_req rises until synced ack=0;
//   pc_req never re-asserts before ack is observed low.
// pc_addr is only sampled in FETCH, after the PC step has completed.
// Step latency: min 3 clk for req->ack (sync + registered edge), 3 clk for release.
// Depth counter: CALL +1, RTN -1. At depth 2**STACK_ADDR_WIDTH-1 a CALL, or at 0 a RTN:
//   stack_err set and the op is still issued (PC wraps); the counter saturates.
// Mid-instruction run=0: the instruction completes, including any second step; then IDLE.
// Async reset mid-handshake: pc_req drops immediately and the FSM returns to IDLE.
//   The PC shares reset, so no stale step survives.
// exec_ready while exec_valid=0 is ignored.
// STRUCTURE
// mc14500_pkg: opcode_t enum (NOPO..NOPF, 4-bit); pc_op_t enum (PC_INC/PC_JMP/PC_RTN/PC_CALL);
//   seq_state_t enum.
// Sub-module sync_2ff: pc_ack synchroniser. Everything else in one always_ff + next-state always_comb.
// TESTING
// 1 Reset, run=1, ROM[0]=LD 0x05, PC model at 0 -> exec_valid with op 0x1 / operand 0x05;
//     after ready one INC handshake; next FETCH rom_addr=0x01.
// 2 ROM[1]=JMP 0x40 -> no exec_valid; pc_op=01, pc_target=0x40; next rom_addr=0x40.
// 3 ROM[0x40]=NOPF 0x80, ROM[0x80]=RTN -> CALL 0x80; then RTN, INC pair; next rom_addr=0x41.
//     depth returns 0, stack_err=0.
// 4 SKZ with rr=0 -> two INC handshakes (addr+2); with rr=1 -> one INC (addr+1).
// 5 RTN at depth 0, or 4 nested CALLs with STACK_ADDR_WIDTH=2 -> stack_err=1 and stays 1 until reset.
// 6 Reset asserted while pc_req=1 and ack delayed 10 clk -> pc_req=0 same cycle, IDLE, busy=0.
//     run=0 during EXEC -> instruction finishes, then IDLE.

Source files
------------

// File: rtl/mc14500_pkg.sv
// Shared types for the MC14500B program sequencer: opcodes, ProgramCounter step ops
// and sequencer FSM states.
package mc14500_pkg;

  localparam int OPCODE_WIDTH = 4;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    NOPO = 4'h0, LD   = 4'h1, LDC  = 4'h2, AND  = 4'h3,
    ANDC = 4'h4, OR   = 4'h5, ORC  = 4'h6, XNOR = 4'h7,
    STO  = 4'h8, STOC = 4'h9, IEN  = 4'hA, OEN  = 4'hB,
    JMP  = 4'hC, RTN  = 4'hD, SKZ  = 4'hE, NOPF = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    PC_INC  = 2'b00,
    PC_JMP  = 2'b01,
    PC_RTN  = 2'b10,
    PC_CALL = 2'b11
  } pc_op_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPTURE, S_EXEC, S_STEP_REQ, S_STEP_REL
  } seq_state_t;

  // Opcodes handed to the execute unit; the rest only steer the PC.
  function automatic logic is_alu(input opcode_t op);
    return op <= OEN;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b0;
      q_reg    <= 1'b0;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetches MC14500B words, feeds ALU ops to the execute unit and
// steps the ProgramCounter over a four-phase req/ack handshake.
module pc_sequencer
  import mc14500_pkg::*;
#(
  parameter int ADDR_WIDTH       = 8,
  parameter int STACK_ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic                  busy,
  output logic                  pc_req,
  input  logic                  pc_ack,
  output logic [1:0]            pc_op,
  output logic [ADDR_WIDTH-1:0] pc_target,
  input  logic [ADDR_WIDTH-1:0] pc_addr,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [ADDR_WIDTH+3:0] rom_data,
  output logic                  exec_valid,
  input  logic                  exec_ready,
  output logic [3:0]            exec_opcode,
  output logic [ADDR_WIDTH-1:0] exec_operand,
  input  logic                  rr,
  output logic                  stack_err
);

  localparam logic [STACK_ADDR_WIDTH-1:0] DEPTH_MAX = '1;
  localparam logic [STACK_ADDR_WIDTH-1:0] DEPTH_ONE = STACK_ADDR_WIDTH'(1);

  seq_state_t                  state_reg, state_next;
  opcode_t                     opcode_reg, opcode_next;
  logic [ADDR_WIDTH-1:0]       operand_reg, operand_next;
  logic [ADDR_WIDTH-1:0]       rom_addr_reg, rom_addr_next;
  logic [ADDR_WIDTH-1:0]       target_reg, target_next;
  pc_op_t                      op_reg, op_next;
  logic                        req_reg, req_next;
  logic                        second_reg, second_next;
  logic                        err_reg, err_next;
  logic [STACK_ADDR_WIDTH-1:0] depth_reg, depth_next;
  logic                        ack_sync;

  sync_2ff u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pc_ack),
    .q     (ack_sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      opcode_reg   <= NOPO;
      operand_reg  <= '0;
      rom_addr_reg <= '0;
      target_reg   <= '0;
      op_reg       <= PC_INC;
      req_reg      <= 1'b0;
      second_reg   <= 1'b0;
      err_reg      <= 1'b0;
      depth_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      opcode_reg   <= opcode_next;
      operand_reg  <= operand_next;
      rom_addr_reg <= rom_addr_next;
      target_reg   <= target_next;
      op_reg       <= op_next;
      req_reg      <= req_next;
      second_reg   <= second_next;
      err_reg      <= err_next;
      depth_reg    <= depth_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    opcode_next   = opcode_reg;
    operand_next  = operand_reg;
    rom_addr_next = rom_addr_reg;
    target_next   = target_reg;
    op_next       = op_reg;
    req_next      = req_reg;
    second_next   = second_reg;
    err_next      = err_reg;
    depth_next    = depth_reg;

    case (state_reg)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        rom_addr_next = pc_addr;
        state_next    = S_CAPTURE;
      end
      S_CAPTURE: begin
        opcode_next  = opcode_t'(rom_data[ADDR_WIDTH +: 4]);
        operand_next = rom_data[ADDR_WIDTH-1:0];
        target_next  = rom_data[ADDR_WIDTH-1:0];
        second_next  = 1'b0;
        if (is_alu(opcode_next)) begin
          state_next = S_EXEC;
        end else begin
          // Op and target settle here, a full cycle before pc_req rises.
          state_next = S_STEP_REQ;
          case (opcode_next)
            JMP: op_next = PC_JMP;
            RTN: begin
              op_next     = PC_RTN;
              second_next = 1'b1;
              if (depth_reg == '0) err_next = 1'b1;
              else depth_next = depth_reg - DEPTH_ONE;
            end
            SKZ: begin
              op_next     = PC_INC;
              second_next = ~rr;
            end
            default: begin
              op_next = PC_CALL;
              if (depth_reg == DEPTH_MAX) err_next = 1'b1;
              else depth_next = depth_reg + DEPTH_ONE;
            end
          endcase
        end
      end
      S_EXEC: begin
        if (exec_ready) begin
          op_next    = PC_INC;
          state_next = S_STEP_REQ;
        end
      end
      S_STEP_REQ: begin
        req_next = 1'b1;
        if (req_reg && ack_sync) begin
          req_next   = 1'b0;
          state_next = S_STEP_REL;
        end
      end
      S_STEP_REL: begin
        if (!ack_sync) begin
          if (second_reg) begin
            second_next = 1'b0;
            op_next     = PC_INC;
            state_next  = S_STEP_REQ;
          end else if (run) begin
            state_next = S_FETCH;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The synchronous ROM must see the PC address during FETCH itself.
  assign rom_addr     = (state_reg == S_FETCH) ? pc_addr : rom_addr_reg;
  assign busy         = (state_reg != S_IDLE);
  assign pc_req       = req_reg;
  assign pc_op        = op_reg;
  assign pc_target    = target_reg;
  assign exec_valid   = (state_reg == S_EXEC);
  assign exec_opcode  = opcode_reg;
  assign exec_operand = operand_reg;
  assign stack_err    = err_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: ROM and ProgramCounter models around the DUT, checked against an
// instruction-level interpreter that predicts every exec transfer and PC step.
module tb_pc_sequencer;
  import mc14500_pkg::*;

  localparam int AW        = 8;
  localparam int SAW       = 2;
  localparam int DEPTH_MAX = (1 << SAW) - 1;

  logic          clk = 1'b0;
  logic          reset, run, exec_ready, rr, pc_ack;
  logic          busy, pc_req, exec_valid, stack_err;
  logic [1:0]    pc_op;
  logic [AW-1:0] pc_target, pc_addr, rom_addr, exec_operand;
  logic [3:0]    exec_opcode;
  logic [AW+3:0] rom_data;

  pc_sequencer #(.ADDR_WIDTH(AW), .STACK_ADDR_WIDTH(SAW)) dut (
    .clk(clk), .reset(reset), .run(run), .busy(busy),
    .pc_req(pc_req), .pc_ack(pc_ack), .pc_op(pc_op), .pc_target(pc_target),
    .pc_addr(pc_addr), .rom_addr(rom_addr), .rom_data(rom_data),
    .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_opcode(exec_opcode),
    .exec_operand(exec_operand), .rr(rr), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Synchronous program ROM
  logic [AW+3:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // ProgramCounter environment model with a variable ack delay
  logic [AW-1:0] pc_val;
  logic [AW-1:0] pc_stack [$];
  int            ack_cnt, ack_delay;
  bit            long_delay = 1'b0;
  assign pc_addr = pc_val;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_val    <= '0;
      pc_stack.delete();
      pc_ack    <= 1'b0;
      ack_cnt   <= 0;
      ack_delay <= 0;
    end else if (pc_req != pc_ack) begin
      if (ack_cnt < (long_delay ? 10 : ack_delay)) begin
        ack_cnt <= ack_cnt + 1;
      end else begin
        ack_cnt   <= 0;
        ack_delay <= int'($urandom_range(0, 2));
        pc_ack    <= pc_req;
        if (pc_req) begin
          case (pc_op)
            2'b00: pc_val <= pc_val + 8'd1;
            2'b01: pc_val <= pc_target;
            2'b10: begin
              if (pc_stack.size() > 0) pc_val <= pc_stack.pop_back();
              else pc_val <= '0;
            end
            default: begin
              pc_stack.push_back(pc_val);
              pc_val <= pc_target;
            end
          endcase
        end
      end
    end else begin
      ack_cnt <= 0;
    end
  end

  // Instruction-level reference: PC, return stack, depth and error flag
  typedef struct {
    bit            is_step;
    logic [3:0]    a;
    logic [AW-1:0] b;
    bit            chk_b;
  } ev_t;

  ev_t           exp_q [$];
  logic [AW-1:0] ref_pc;
  logic [AW-1:0] ref_stack [$];
  int            ref_depth;
  bit            ref_err;
  int            insts_done;
  int            exec_count;
  bit            rand_rr = 1'b0;
  bit            ready_hold = 1'b0;

  task automatic push_ev(input bit is_step, input logic [3:0] a, input logic [AW-1:0] b,
                         input bit chk_b);
    ev_t e;
    e.is_step = is_step; e.a = a; e.b = b; e.chk_b = chk_b;
    exp_q.push_back(e);
  endtask

  task automatic predict();
    logic [3:0]    op;
    logic [AW-1:0] opd;
    logic [AW-1:0] ret;
    {op, opd} = rom[ref_pc];
    if (op <= 4'hB) begin
      push_ev(1'b0, op, opd, 1'b1);
      push_ev(1'b1, 4'd0, '0, 1'b0);
      ref_pc = ref_pc + 8'd1;
    end else if (op == 4'hC) begin
      push_ev(1'b1, 4'd1, opd, 1'b1);
      ref_pc = opd;
    end else if (op == 4'hD) begin
      if (ref_depth == 0) ref_err = 1'b1;
      else ref_depth--;
      ret = '0;
      if (ref_stack.size() > 0) ret = ref_stack.pop_back();
      push_ev(1'b1, 4'd2, '0, 1'b0);
      push_ev(1'b1, 4'd0, '0, 1'b0);
      ref_pc = ret + 8'd1;
    end else if (op == 4'hE) begin
      push_ev(1'b1, 4'd0, '0, 1'b0);
      if (!rr) begin
        push_ev(1'b1, 4'd0, '0, 1'b0);
        ref_pc = ref_pc + 8'd2;
      end else begin
        ref_pc = ref_pc + 8'd1;
      end
    end else begin
      if (ref_depth == DEPTH_MAX) ref_err = 1'b1;
      else ref_depth++;
      ref_stack.push_back(ref_pc);
      push_ev(1'b1, 4'd3, opd, 1'b1);
      ref_pc = opd;
    end
  endtask

  task automatic handle_event(input bit is_step, input logic [3:0] a, input logic [AW-1:0] b);
    ev_t e;
    if (exp_q.size() == 0) predict();
    e = exp_q.pop_front();
    $display("[%0t] %s a=%0h b=%0h", $time, is_step ? "step" : "exec", a, b);
    check(is_step ? "step_kind" : "exec_kind", 32'(is_step), 32'(e.is_step));
    check(is_step ? "step_op" : "exec_opcode", a, e.a);
    if (e.chk_b) check(is_step ? "step_target" : "exec_operand", b, e.b);
    if (is_step) check("stack_err", stack_err, ref_err);
    if (exp_q.size() == 0) insts_done++;
  endtask

  // Monitor: samples on the falling edge, away from DUT updates
  logic          req_d;
  logic [1:0]    op_d;
  logic [AW-1:0] tgt_d;
  always @(negedge clk) begin
    if (reset) begin
      req_d = 1'b0;
      op_d  = pc_op;
      tgt_d = pc_target;
    end else begin
      if (exec_valid && exec_ready) begin
        exec_count++;
        handle_event(1'b0, exec_opcode, exec_operand);
        if (rand_rr) rr = 1'($urandom_range(0, 1));
      end
      if (pc_req && !req_d) begin
        check("req_while_ack", pc_ack, 1'b0);
        handle_event(1'b1, {2'b00, pc_op}, pc_target);
      end
      if (pc_req || pc_ack) begin
        check("op_stable", pc_op, op_d);
        check("target_stable", pc_target, tgt_d);
      end
      req_d = pc_req;
      op_d  = pc_op;
      tgt_d = pc_target;
    end
  end

  initial begin
    exec_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      exec_ready = ready_hold ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  task automatic clear_ref();
    exp_q.delete();
    ref_stack.delete();
    ref_pc     = '0;
    ref_depth  = 0;
    ref_err    = 1'b0;
    insts_done = 0;
    exec_count = 0;
  endtask

  task automatic restart();
    @(posedge clk);
    #2;
    reset = 1'b1;
    run   = 1'b0;
    clear_ref();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic fill_default();
    for (int i = 0; i < 256; i++) rom[i] = {4'(i % 12), 8'(i)};
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (busy && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic stop_and_idle();
    @(posedge clk);
    #2 run = 1'b0;
    wait_idle();
    check("exp_q_empty", exp_q.size(), 0);
    check("pc_final", pc_val, ref_pc);
    check("stack_err_idle", stack_err, ref_err);
  endtask

  task automatic run_insts(input int n);
    int cyc = 0;
    run = 1'b1;
    while (insts_done < n && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    check("insts_timeout", 32'(insts_done >= n), 1);
    stop_and_idle();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int r;
    reset = 1'b1;
    run   = 1'b0;
    rr    = 1'b0;
    clear_ref();
    fill_default();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_req", pc_req, 1'b0);
    check("rst_op", pc_op, 2'b00);
    check("rst_target", pc_target, 8'h00);
    check("rst_rom_addr", rom_addr, 8'h00);
    check("rst_exec_valid", exec_valid, 1'b0);
    check("rst_exec_opcode", exec_opcode, 4'h0);
    check("rst_stack_err", stack_err, 1'b0);
    #1 reset = 1'b0;

    // LD, JMP, CALL/RTN, SKZ, STO, then a JMP-to-self loop; with rr=0 and rr=1
    rom[8'h00] = {4'h1, 8'h05};
    rom[8'h01] = {4'hC, 8'h40};
    rom[8'h40] = {4'hF, 8'h80};
    rom[8'h80] = {4'hD, 8'h00};
    rom[8'h41] = {4'hE, 8'h00};
    rom[8'h42] = {4'h5, 8'h11};
    rom[8'h43] = {4'h8, 8'h22};
    rom[8'h44] = {4'hC, 8'h44};
    for (int pass = 0; pass < 2; pass++) begin
      restart();
      rr = 1'(pass);
      run_insts(9);
      check("dir_pc_loop", pc_val, 8'h44);
      check("dir_exec_count", exec_count, (pass == 0) ? 2 : 3);
      check("dir_stack_err", stack_err, 1'b0);
    end

    // RTN at depth 0 sets a sticky error
    fill_default();
    rom[8'h00] = {4'hD, 8'h00};
    restart();
    run_insts(3);
    check("rtn_underflow_err", stack_err, 1'b1);
    repeat (20) @(posedge clk);
    #1 check("err_sticky", stack_err, 1'b1);
    restart();
    #1 check("err_cleared_by_reset", stack_err, 1'b0);

    // Four nested CALLs overflow the tracked depth
    rom[8'h00] = {4'hF, 8'h10};
    rom[8'h10] = {4'hF, 8'h20};
    rom[8'h20] = {4'hF, 8'h30};
    rom[8'h30] = {4'hF, 8'h40};
    rom[8'h40] = {4'hC, 8'h40};
    restart();
    run_insts(5);
    check("call_overflow_err", stack_err, 1'b1);
    check("call_overflow_pc", pc_val, 8'h40);

    // Reset in the middle of a slow handshake
    fill_default();
    restart();
    long_delay = 1'b1;
    run = 1'b1;
    cyc = 0;
    while (!pc_req && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("req_seen", pc_req, 1'b1);
    repeat (3) @(posedge clk);
    #1 check("req_held_slow_ack", pc_req, 1'b1);
    #1 reset = 1'b1;
    run = 1'b0;
    #1;
    check("reset_req_drop", pc_req, 1'b0);
    check("reset_busy", busy, 1'b0);
    clear_ref();
    long_delay = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // run dropped while an instruction waits in EXEC
    restart();
    ready_hold = 1'b1;
    run = 1'b1;
    cyc = 0;
    while (!exec_valid && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("exec_valid_seen", exec_valid, 1'b1);
    #1 run = 1'b0;
    repeat (3) @(posedge clk);
    #2 ready_hold = 1'b0;
    wait_idle();
    check("stop_insts", insts_done, 1);
    check("stop_pc", pc_val, 8'h01);

    // Randomised programs
    for (int i = 0; i < 256; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      rom[i] = {4'($urandom_range(0, 11)), 8'($urandom)};
      else if (r < 78) rom[i] = {4'hE, 8'($urandom)};
      else if (r < 86) rom[i] = {4'hC, 8'($urandom)};
      else if (r < 93) rom[i] = {4'hF, 8'($urandom)};
      else             rom[i] = {4'hD, 8'($urandom)};
    end
    restart();
    rand_rr = 1'b1;
    for (int k = 1; k <= 6; k++) run_insts(k * 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
